ext_uart: RTL
=============

Name: ext_uart

Overview:
- 8N1 UART peripheral that is the responder on the SoC external bus (o_ext_addr/stb/we/dat_w in; ack/dat_r out).
- Sits outside the SoC and gives the CPU a serial console through the external address window (0x2000_0000).
- TX and RX each have a small synchronous FIFO, and the baud divisor is programmable.

Parameters:
- FIFO_DEPTH, 16, entries per TX and RX FIFO (power of two, at least 2).
- DEFAULT_DIV, 16'd434, reset value of the divisor register, in clocks per bit.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_addr  in  16  byte address from the external bus; only [3:2] is decoded.
- i_stb  in  1  bus strobe.
- i_we  in  4  byte-lane write enables; 0 means read.
- i_dat_w  in  32  write data.
- o_ack  out  1  one-cycle acknowledge.
- o_dat_r  out  32  read data, valid while o_ack is high.
- i_rx  in  1  serial input, asynchronous.
- o_tx  out  1  serial output, idle high.

Behaviour:
- Reset values: o_tx=1, o_ack=0, o_dat_r=0, FIFOs empty, sticky flags 0, divisor=DEFAULT_DIV, both FSMs in IDLE. Reset mid-frame aborts immediately and o_tx returns to 1 asynchronously.
- Handshake:
  - o_ack <= i_stb & ~o_ack, so ack comes 1 cycle after stb.
  - If stb stays held, ack alternates between 1 and 0.
  - Every register side effect (push, pop, flag clear) happens exactly once, in the cycle o_ack is set.
- Register map by i_addr[3:2]:
  - 0 DATA: write with i_we[0] pushes i_dat_w[7:0] to the TX FIFO. A read pops the RX FIFO and returns {24'b0, byte}.
  - 1 STATUS (read-only):
    - bit0 rx_valid
    - bit1 tx_full
    - bit2 tx_empty (FIFO empty and TX FSM idle)
    - bit3 rx_overrun (sticky)
    - bit4 rx_frame_err (sticky)
    - A STATUS read clears bits 3 and 4 after returning them.
  - 2 DIVISOR: bits [15:0] read/write. Writes below 2 are stored as 2. The new value takes effect at the next frame start of each FSM.
  - 3: reads 0; writes are ignored.
- Bus boundary cases:
  - Writing DATA when the TX FIFO is full drops the byte; the access is still acked.
  - Reading DATA when the RX FIFO is empty returns 0 and does not pop.
  - A DATA write with i_we[0]=0 is ignored.
- TX FSM: IDLE → START → DATA×8 (LSB first) → STOP → IDLE.
  - Each state lasts divisor clocks.
  - It leaves IDLE the cycle after the TX FIFO is non-empty and pops the byte in that cycle.
  - Back-to-back frames need no extra idle bit.
- RX path: 2-FF synchronizer on i_rx, then FSM IDLE → START → DATA → STOP.
  - IDLE: a synced falling edge starts a count of divisor/2.
  - START: line is re-checked low; if high it is a glitch and the FSM returns to IDLE.
  - DATA: 8 samples taken every divisor clocks, LSB first.
  - STOP: sampled after one more divisor.
    - Stop=1: push the byte. If the RX FIFO is full, discard the byte and set rx_overrun.
    - Stop=0: discard the byte and set rx_frame_err.
  - RX returns to IDLE right after the stop sample, so it can resync to a start bit within half a bit.
- FIFO simultaneous push and pop:
  - Both are allowed in the same cycle; the count is unchanged.
  - Full with pop and push: the push succeeds.
  - Empty with push and pop: the pop is not serviced.

Optional Feature:
- Macro: EXT_UART_LOOPBACK_EN.
- Defined:
  - Register 3 becomes CTRL; bit0 is loop, read/write, reset 0.
  - With loop=1, the RX input is the TX shift output (before o_tx), and o_tx is held at 1.
- Undefined: register 3 behaves as reserved, as described above.

Decomposition:
- Package ext_uart_pkg holds:
  - register offsets: REG_DATA=2'd0, REG_STATUS=2'd1, REG_DIV=2'd2, REG_CTRL=2'd3
  - STATUS bit indices
  - TX and RX state enum typedefs
  - DIV_MIN=16'd2
- Sub-module ext_uart_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, dout), instantiated twice.

Test Plan:
- Reset value checks:
  - Stimulus: reset, then read STATUS and DIVISOR.
  - Required: STATUS=0x4 and DIVISOR=434.
  - Required: o_tx=1 throughout.
  - Required: each access acked exactly 1 cycle after stb.
- TX frame:
  - Stimulus: DIVISOR=4, write DATA 0xA5.
  - Required: o_tx shows start 0, bits 1,0,1,0,0,1,0,1, then stop 1.
  - Required: each bit is 4 clocks wide.
  - Required: tx_empty returns to 1 after the stop bit.
- TX overflow:
  - Stimulus: DIVISOR=4, write FIFO_DEPTH+2 bytes 0x00..0x11 back-to-back.
  - Required: tx_full=1 after 16 accepted bytes (the one in flight excluded).
  - Required: the last dropped byte never appears on o_tx.
- RX receive:
  - Stimulus: drive 0x3C on i_rx at 4 clocks/bit.
  - Required: rx_valid=1; a DATA read returns 0x0000003C; a second read returns 0 and rx_valid=0.
- RX error cases:
  - Stimulus: drive 17 frames with no reads.
  - Required: rx_overrun=1 and it clears after one STATUS read.
  - Stimulus: a frame with stop bit 0.
  - Required: rx_frame_err=1 and no push.
  - Stimulus: a 1-clock low glitch on i_rx.
  - Required: nothing received.
- Loopback (EXT_UART_LOOPBACK_EN defined):
  - Stimulus: CTRL=1, write 0x5A.
  - Required: 0x5A is read back from DATA; o_tx stays 1.

Source files
------------

// File: rtl/ext_uart_pkg.sv
// Shared register offsets, status bit positions and FSM encodings for ext_uart.
package ext_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned ST_RX_VALID     = 0;
  localparam int unsigned ST_TX_FULL      = 1;
  localparam int unsigned ST_TX_EMPTY     = 2;
  localparam int unsigned ST_RX_OVERRUN   = 3;
  localparam int unsigned ST_RX_FRAME_ERR = 4;
  localparam int unsigned ST_W            = 5;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/ext_uart_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees room for a same-cycle push.
module ext_uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ext_uart.sv
// 8N1 UART responder on the external bus with TX/RX FIFOs and programmable divisor.
// Optional EXT_UART_LOOPBACK_EN adds CTRL.loop at offset 3 (TX shift output feeds RX).
module ext_uart
  import ext_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_addr,
  input  logic        i_stb,
  input  logic [3:0]  i_we,
  input  logic [31:0] i_dat_w,
  output logic        o_ack,
  output logic [31:0] o_dat_r,
  input  logic        i_rx,
  output logic        o_tx
);

  logic        ack_q;
  logic [31:0] dat_r_q, dat_r_d;
  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d, ferr_q, ferr_d;
  logic        acc, rd;
  logic [1:0]  sel;
  logic        tx_push, rx_pop, clr_sticky;
  logic [ST_W-1:0] status;

  logic        txf_full, txf_empty, rxf_full, rxf_empty;
  logic [7:0]  txf_dout, rxf_dout;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_line_q, tx_line_d, tx_pop, tx_last;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q, rx_src;
  logic        rx_push, ferr_set, ovr_set, rx_bit_end, rx_half_end;

  logic        unused_bits;
  assign unused_bits = ^{i_addr[15:4], i_addr[1:0], i_we[3:2], i_dat_w[31:16]};

`ifdef EXT_UART_LOOPBACK_EN
  logic loop_q, loop_d, tx_pin_q;
  assign rx_src = loop_q ? tx_line_q : i_rx;
  assign o_tx   = tx_pin_q;
`else
  assign rx_src = i_rx;
  assign o_tx   = tx_line_q;
`endif

  assign o_ack   = ack_q;
  assign o_dat_r = dat_r_q;
  assign acc     = i_stb & ~ack_q;
  assign rd      = (i_we == 4'd0);
  assign sel     = i_addr[3:2];
  assign status  = {ferr_q, ovr_q, txf_empty & (tx_state_q == TX_IDLE), txf_full, ~rxf_empty};

  // Register decode; every side effect is qualified by the ack-setting cycle.
  always_comb begin
    tx_push    = 1'b0;
    rx_pop     = 1'b0;
    clr_sticky = 1'b0;
    div_d      = div_q;
    dat_r_d    = '0;
`ifdef EXT_UART_LOOPBACK_EN
    loop_d     = loop_q;
`endif
    if (acc) begin
      case (sel)
        REG_DATA: begin
          if (rd) begin
            rx_pop  = ~rxf_empty;
            dat_r_d = rxf_empty ? 32'd0 : {24'd0, rxf_dout};
          end else if (i_we[0]) begin
            tx_push = 1'b1;
          end
        end
        REG_STATUS: begin
          if (rd) begin
            dat_r_d    = 32'(status);
            clr_sticky = 1'b1;
          end
        end
        REG_DIV: begin
          if (rd) dat_r_d = {16'd0, div_q};
          else    div_d   = clamp_div({i_we[1] ? i_dat_w[15:8] : div_q[15:8],
                                       i_we[0] ? i_dat_w[7:0]  : div_q[7:0]});
        end
        REG_CTRL: begin
`ifdef EXT_UART_LOOPBACK_EN
          if (rd)           dat_r_d = {31'd0, loop_q};
          else if (i_we[0]) loop_d  = i_dat_w[0];
`endif
        end
        default: ;
      endcase
    end
  end

  // A new error event wins over a same-cycle clear so it is never lost.
  assign ovr_set = rx_push & rxf_full & ~rx_pop;
  assign ovr_d   = (ovr_q & ~clr_sticky) | ovr_set;
  assign ferr_d  = (ferr_q & ~clr_sticky) | ferr_set;

  assign tx_last = (tx_cnt_q == tx_div_q - 16'd1);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_div_d   = tx_div_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        if (!txf_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = txf_dout;
          tx_div_d   = div_q;
          tx_state_d = TX_START;
          tx_line_d  = 1'b0;
        end
      end
      TX_START: if (tx_last) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
        tx_line_d  = tx_shift_q[0];
      end
      TX_DATA: if (tx_last) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          tx_line_d  = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_line_d  = tx_shift_q[1];
        end
      end
      TX_STOP: if (tx_last) begin
        tx_cnt_d = '0;
        if (!txf_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = txf_dout;
          tx_div_d   = div_q;
          tx_state_d = TX_START;
          tx_line_d  = 1'b0;
        end else begin
          tx_state_d = TX_IDLE;
          tx_line_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rx_bit_end  = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_half_end = (rx_cnt_q == {1'b0, rx_div_q[15:1]} - 16'd1);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_div_d   = rx_div_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q & ~rx_sync_q) begin
          rx_div_d   = div_q;
          rx_state_d = RX_START;
        end
      end
      RX_START: if (rx_half_end) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end
      RX_STOP: if (rx_bit_end) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        if (rx_sync_q) rx_push  = 1'b1;
        else           ferr_set = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q      <= 1'b0;
      dat_r_q    <= '0;
      div_q      <= DEFAULT_DIV;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DEFAULT_DIV;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DEFAULT_DIV;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
`ifdef EXT_UART_LOOPBACK_EN
      loop_q     <= 1'b0;
      tx_pin_q   <= 1'b1;
`endif
    end else begin
      ack_q      <= i_stb & ~ack_q;
      dat_r_q    <= dat_r_d;
      div_q      <= div_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_meta_q  <= rx_src;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
`ifdef EXT_UART_LOOPBACK_EN
      loop_q     <= loop_d;
      tx_pin_q   <= tx_line_d | loop_q;
`endif
    end
  end

  ext_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(i_clk), .rst_i(i_rst), .push_i(tx_push), .din_i(i_dat_w[7:0]),
    .pop_i(tx_pop), .full_o(txf_full), .empty_o(txf_empty), .dout_o(txf_dout)
  );

  ext_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(i_clk), .rst_i(i_rst), .push_i(rx_push), .din_i(rx_shift_q),
    .pop_i(rx_pop), .full_o(rxf_full), .empty_o(rxf_empty), .dout_o(rxf_dout)
  );

endmodule
